// File: rtl/imm_decode_buf.sv
// RV32I immediate decoder: classifies the immediate format, builds the extended
// immediate and pc+imm target, and hands results out through a 2-entry buffer.
module imm_decode_buf #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [2:0]       imm_type_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [XLEN-1:0]  target_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [2:0] T_U = 3'b000;
  localparam logic [2:0] T_J = 3'b001;
  localparam logic [2:0] T_B = 3'b010;
  localparam logic [2:0] T_S = 3'b011;
  localparam logic [2:0] T_I = 3'b100;
  localparam logic [2:0] T_Z = 3'b101;
  localparam logic [2:0] T_R = 3'b110;
  localparam logic [2:0] T_X = 3'b111;

  function automatic logic [2:0] decode_type(input logic [31:0] ins);
    logic [2:0] t;
    case (ins[6:0])
      7'b0110111, 7'b0010111:                         t = T_U;
      7'b1101111:                                     t = T_J;
      7'b1100011:                                     t = T_B;
      7'b0100011:                                     t = T_S;
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: t = T_I;
      7'b1110011:                                     t = ins[14] ? T_Z : T_I;
      7'b0110011:                                     t = T_R;
      default:                                        t = T_X;
    endcase
    return t;
  endfunction

  // Build a 32-bit signed immediate, then widen; the cast sign-extends.
  function automatic logic [XLEN-1:0] build_imm(input logic [2:0] t, input logic [31:0] ins);
    logic signed [31:0] v;
    case (t)
      T_U:     v = {ins[31:12], 12'b0};
      T_J:     v = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      T_B:     v = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      T_S:     v = {{21{ins[31]}}, ins[30:25], ins[11:7]};
      T_I:     v = {{21{ins[31]}}, ins[30:20]};
      T_Z:     v = {27'b0, ins[19:15]};
      default: v = '0;
    endcase
    return XLEN'(v);
  endfunction

  logic [1:0]       count_q, count_d;
  logic [2:0]       head_type_q, head_type_d, spare_type_q, spare_type_d;
  logic [XLEN-1:0]  head_imm_q, head_imm_d, spare_imm_q, spare_imm_d;
  logic [XLEN-1:0]  head_tgt_q, head_tgt_d, spare_tgt_q, spare_tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             push, pop;
  logic [2:0]       new_type;
  logic [XLEN-1:0]  new_imm, new_tgt;

  always_comb begin
    new_type = decode_type(instr_i);
    new_imm  = build_imm(new_type, instr_i);
    new_tgt  = pc_i + new_imm;
    push     = in_valid_i && (count_q != 2'd2);
    pop      = out_ready_i && (count_q != 2'd0);

    count_d      = count_q;
    head_type_d  = head_type_q;
    head_imm_d   = head_imm_q;
    head_tgt_d   = head_tgt_q;
    spare_type_d = spare_type_q;
    spare_imm_d  = spare_imm_q;
    spare_tgt_d  = spare_tgt_q;
    cnt_d        = cnt_q;

    // Head register doubles as the output; it keeps the last popped entry when empty.
    if (pop && count_q == 2'd2) begin
      head_type_d = spare_type_q;
      head_imm_d  = spare_imm_q;
      head_tgt_d  = spare_tgt_q;
    end else if (push && (count_q == 2'd0 || pop)) begin
      head_type_d = new_type;
      head_imm_d  = new_imm;
      head_tgt_d  = new_tgt;
    end else if (push) begin
      spare_type_d = new_type;
      spare_imm_d  = new_imm;
      spare_tgt_d  = new_tgt;
    end

    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;

    if (push && new_type == T_X && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q      <= 2'd0;
      head_type_q  <= T_R;
      head_imm_q   <= '0;
      head_tgt_q   <= '0;
      spare_type_q <= T_R;
      spare_imm_q  <= '0;
      spare_tgt_q  <= '0;
      cnt_q        <= '0;
    end else begin
      count_q      <= count_d;
      head_type_q  <= head_type_d;
      head_imm_q   <= head_imm_d;
      head_tgt_q   <= head_tgt_d;
      spare_type_q <= spare_type_d;
      spare_imm_q  <= spare_imm_d;
      spare_tgt_q  <= spare_tgt_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready_o    = (count_q != 2'd2);
  assign out_valid_o   = (count_q != 2'd0);
  assign imm_type_o    = head_type_q;
  assign imm_o         = head_imm_q;
  assign target_o      = head_tgt_q;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_imm_decode_buf.sv
// Directed bench for imm_decode_buf: one XLEN=32/CNT_W=16 instance and one
// XLEN=64/CNT_W=2 instance, checked with immediate assertions.
module tb_imm_decode_buf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: XLEN=32, CNT_W=16
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_instr, a_pc, a_imm, a_tgt;
  logic [2:0]  a_type;
  logic [15:0] a_cnt;

  // Instance B: XLEN=64, CNT_W=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_instr;
  logic [63:0] b_pc, b_imm, b_tgt;
  logic [2:0]  b_type;
  logic [1:0]  b_cnt;

  imm_decode_buf #(.XLEN(32), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .instr_i(a_instr), .pc_i(a_pc),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .imm_type_o(a_type), .imm_o(a_imm), .target_o(a_tgt),
    .illegal_cnt_o(a_cnt)
  );

  imm_decode_buf #(.XLEN(64), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .instr_i(b_instr), .pc_i(b_pc),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .imm_type_o(b_type), .imm_o(b_imm), .target_o(b_tgt),
    .illegal_cnt_o(b_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [2:0] t,
                       input logic [31:0] imm, input logic [31:0] tgt);
    chk({tag, ".valid"}, 64'(a_out_valid), 64'(v));
    chk({tag, ".type"},  64'(a_type), 64'(t));
    chk({tag, ".imm"},   64'(a_imm), 64'(imm));
    chk({tag, ".tgt"},   64'(a_tgt), 64'(tgt));
  endtask

  task automatic chk_b(input string tag, input logic [2:0] t,
                       input logic [63:0] imm, input logic [63:0] tgt);
    chk({tag, ".valid"}, 64'(b_out_valid), 64'd1);
    chk({tag, ".type"},  64'(b_type), 64'(t));
    chk({tag, ".imm"},   b_imm, imm);
    chk({tag, ".tgt"},   b_tgt, tgt);
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_out_ready = 0; a_instr = '0; a_pc = '0;
    b_in_valid = 0; b_out_ready = 0; b_instr = '0; b_pc = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset then idle for five cycles
    for (int i = 0; i < 5; i++) begin
      chk("idle.a_valid", 64'(a_out_valid), 64'd0);
      chk("idle.a_ready", 64'(a_in_ready), 64'd1);
      chk("idle.a_cnt",   64'(a_cnt), 64'd0);
      chk("idle.a_type",  64'(a_type), 64'(3'b110));
      chk("idle.a_imm",   64'(a_imm), 64'd0);
      chk("idle.b_type",  64'(b_type), 64'(3'b110));
      chk("idle.b_valid", 64'(b_out_valid), 64'd0);
      tick();
    end

    // Back-to-back pushes with the consumer always ready
    a_out_ready = 1;
    a_in_valid = 1; a_instr = 32'hFFDFF0EF; a_pc = 32'h0;
    chk("bb.pre_valid", 64'(a_out_valid), 64'd0);
    tick();
    chk_a("bb.jal", 1, 3'b001, 32'hFFFFFFFC, 32'hFFFFFFFC);
    a_instr = 32'h00000463; a_pc = 32'h100;
    tick();
    chk_a("bb.beq", 1, 3'b010, 32'h8, 32'h108);
    a_instr = 32'hFE20AC23; a_pc = 32'h200;
    tick();
    chk_a("bb.sw", 1, 3'b011, 32'hFFFFFFF8, 32'h1F8);
    a_instr = 32'h3002D073; a_pc = 32'h300;
    tick();
    chk_a("bb.csrrwi", 1, 3'b101, 32'h5, 32'h305);
    a_in_valid = 0;
    tick();
    chk_a("bb.drained_hold", 0, 3'b101, 32'h5, 32'h305);
    chk("bb.ready", 64'(a_in_ready), 64'd1);

    // Backpressure: three words offered with the consumer stalled
    a_out_ready = 0; a_pc = 32'h0;
    a_in_valid = 1; a_instr = 32'h00500093;
    tick();
    chk_a("bp.w1", 1, 3'b100, 32'd5, 32'd5);
    chk("bp.ready1", 64'(a_in_ready), 64'd1);
    a_instr = 32'h00A00113;
    tick();
    chk("bp.ready2", 64'(a_in_ready), 64'd0);
    chk_a("bp.head_w1", 1, 3'b100, 32'd5, 32'd5);
    a_instr = 32'h12345037;
    tick();
    chk("bp.ready3", 64'(a_in_ready), 64'd0);
    chk_a("bp.stable_w1", 1, 3'b100, 32'd5, 32'd5);
    a_out_ready = 1;
    tick();
    chk_a("bp.w2", 1, 3'b100, 32'd10, 32'd10);
    chk("bp.ready_after_pop", 64'(a_in_ready), 64'd1);
    tick();
    chk_a("bp.w3", 1, 3'b000, 32'h12345000, 32'h12345000);
    a_in_valid = 0;
    tick();
    chk("bp.empty", 64'(a_out_valid), 64'd0);

    // Illegal opcodes on the 32-bit instance
    a_in_valid = 1; a_instr = 32'h0000007F; a_pc = 32'h40;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_a("ill.a", 1, 3'b111, 32'h0, 32'h40);
      chk("ill.a_cnt", 64'(a_cnt), 64'(i));
    end
    a_in_valid = 0;
    tick();

    // 64-bit instance: sign extension to XLEN
    b_out_ready = 1;
    b_in_valid = 1; b_instr = 32'hFFF00093; b_pc = 64'h1000;
    tick();
    chk_b("x64.addi", 3'b100, 64'hFFFFFFFFFFFFFFFF, 64'h0FFF);
    b_instr = 32'h800002B7; b_pc = 64'h0;
    tick();
    chk_b("x64.lui_neg", 3'b000, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000);
    b_instr = 32'h123452B7; b_pc = 64'h10;
    tick();
    chk_b("x64.lui_pos", 3'b000, 64'h0000000012345000, 64'h0000000012345010);

    // CNT_W=2 saturation
    b_instr = 32'h0000007F; b_pc = 64'h0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_b("sat.b", 3'b111, 64'h0, 64'h0);
      chk("sat.b_cnt", 64'(b_cnt), 64'((i > 3) ? 3 : i));
    end
    b_in_valid = 0;
    tick();

    // Asynchronous reset with two entries buffered
    a_out_ready = 0;
    a_in_valid = 1; a_instr = 32'h00500093; a_pc = 32'h0;
    tick(); tick();
    a_in_valid = 0;
    chk("mr.full", 64'(a_in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mr.valid", 64'(a_out_valid), 64'd0);
    chk("mr.ready", 64'(a_in_ready), 64'd1);
    chk("mr.cnt",   64'(a_cnt), 64'd0);
    chk("mr.type",  64'(a_type), 64'(3'b110));
    chk("mr.imm",   64'(a_imm), 64'd0);
    chk("mr.tgt",   64'(a_tgt), 64'd0);
    tick();
    rst = 1'b0;
    a_out_ready = 1;
    a_in_valid = 1; a_instr = 32'h00000463; a_pc = 32'h100;
    #2;
    chk("mr.no_bypass", 64'(a_out_valid), 64'd0);
    tick();
    chk_a("mr.after", 1, 3'b010, 32'h8, 32'h108);
    a_in_valid = 0;
    tick();
    chk("mr.drained", 64'(a_out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
